// File: rtl/gen3_block_sequencer.sv
// Gen3 128b/130b block sequencer: sync-header checking, block lock FSM and
// per-byte valid-mask generation for the Gen3 datapath.
module gen3_block_sequencer #(
  parameter int unsigned LANES       = 16,
  parameter int unsigned LOCK_BLOCKS = 4,
  parameter int unsigned ERR_LIMIT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sh_valid,
  input  logic [2*LANES-1:0]   in_sh,
  input  logic                 force_relock,
  output logic [4*LANES-1:0]   dp_valid,
  output logic                 dp_os,
  output logic [1:0]           blk_phase,
  output logic                 locked,
  output logic [7:0]           sh_err_cnt
);

  localparam int unsigned MASK_W = 4 * LANES;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_OS   = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [CNT_W-1:0]   good_q, good_d;
  logic [CNT_W-1:0]   bad_q, bad_d;
  logic               blk_os_q, blk_os_d;
  logic               blk_bad_q, blk_bad_d;
  logic               blk_pass_q, blk_pass_d;

  logic [MASK_W-1:0]  dp_valid_d;
  logic               dp_os_d;
  logic [1:0]         blk_phase_d;
  logic               locked_d;
  logic [7:0]         sh_err_cnt_d;

  logic               lanes_equal_c;
  logic               lane0_ok_c;
  logic               hdr_good_c;
  logic               good_evt_c;
  logic               bad_evt_c;
  logic [CNT_W-1:0]   good_inc_c;
  logic [CNT_W-1:0]   bad_inc_c;

  // Header is good when present, every lane carries a legal code and all agree.
  always_comb begin
    lanes_equal_c = 1'b1;
    for (int i = 1; i < LANES; i++) begin
      if (in_sh[2*i +: 2] != in_sh[1:0]) begin
        lanes_equal_c = 1'b0;
      end
    end
  end

  assign lane0_ok_c = (in_sh[1:0] == SH_DATA) || (in_sh[1:0] == SH_OS);
  assign hdr_good_c = in_sh_valid && lanes_equal_c && lane0_ok_c;
  assign good_inc_c = good_q + CNT_W'(1);
  assign bad_inc_c  = bad_q + CNT_W'(1);

  // Next-state, block tracking and output decode.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    good_d       = good_q;
    bad_d        = bad_q;
    blk_os_d     = blk_os_q;
    blk_bad_d    = blk_bad_q;
    blk_pass_d   = blk_pass_q;
    sh_err_cnt_d = sh_err_cnt;
    blk_phase_d  = blk_phase;
    dp_valid_d   = '0;
    dp_os_d      = 1'b0;
    good_evt_c   = 1'b0;
    bad_evt_c    = 1'b0;

    if (force_relock) begin
      state_d     = IDLE;
      phase_d     = 2'd0;
      good_d      = '0;
      bad_d       = '0;
      blk_os_d    = 1'b0;
      blk_bad_d   = 1'b0;
      blk_pass_d  = 1'b0;
      blk_phase_d = 2'd0;
    end else if (in_valid) begin
      blk_phase_d = phase_q;
      case (state_q)
        IDLE: begin
          if (hdr_good_c) begin
            state_d    = (LOCK_BLOCKS == 1) ? LOCKED : LOCKING;
            good_d     = CNT_W'(1);
            phase_d    = 2'd1;
            blk_os_d   = (in_sh[1:0] == SH_OS);
            blk_bad_d  = 1'b0;
            blk_pass_d = 1'b0;
          end
        end
        default: begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd0) begin
            // Block type and pass eligibility are fixed by the phase-0 header.
            blk_os_d   = (in_sh[1:0] == SH_OS);
            blk_bad_d  = !hdr_good_c;
            blk_pass_d = (state_q == LOCKED) && hdr_good_c;
            good_evt_c = hdr_good_c;
            bad_evt_c  = !hdr_good_c;
          end else if (in_sh_valid && !blk_bad_q) begin
            blk_bad_d = 1'b1;
            bad_evt_c = 1'b1;
          end

          if (good_evt_c) begin
            if (state_q == LOCKING) begin
              good_d = good_inc_c;
              if (good_inc_c == CNT_W'(LOCK_BLOCKS)) begin
                state_d = LOCKED;
              end
            end else begin
              bad_d = '0;
            end
          end

          if (bad_evt_c) begin
            if (state_q == LOCKING) begin
              state_d = IDLE;
              good_d  = '0;
              phase_d = 2'd0;
            end else begin
              if (sh_err_cnt != 8'hFF) begin
                sh_err_cnt_d = sh_err_cnt + 8'd1;
              end
              bad_d = bad_inc_c;
              if (bad_inc_c == CNT_W'(ERR_LIMIT)) begin
                state_d = IDLE;
                bad_d   = '0;
                good_d  = '0;
                phase_d = 2'd0;
              end
            end
          end

          if (blk_pass_d && !blk_bad_d) begin
            if (blk_os_d) begin
              dp_os_d = 1'b1;
            end else begin
              dp_valid_d = '1;
            end
          end
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= 2'd0;
      good_q     <= '0;
      bad_q      <= '0;
      blk_os_q   <= 1'b0;
      blk_bad_q  <= 1'b0;
      blk_pass_q <= 1'b0;
      dp_valid   <= '0;
      dp_os      <= 1'b0;
      blk_phase  <= 2'd0;
      locked     <= 1'b0;
      sh_err_cnt <= 8'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      blk_os_q   <= blk_os_d;
      blk_bad_q  <= blk_bad_d;
      blk_pass_q <= blk_pass_d;
      dp_valid   <= dp_valid_d;
      dp_os      <= dp_os_d;
      blk_phase  <= blk_phase_d;
      locked     <= locked_d;
      sh_err_cnt <= sh_err_cnt_d;
    end
  end

endmodule
